// File: rtl/ddr_burst_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_burst_responder_pkg
// Description : Shared types and constants for the DDR burst responder:
//               FSM state encoding, app command encodings and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_burst_responder_pkg;

  localparam int DEF_DDR_DATA_WIDTH  = 128;
  localparam int DEF_DDR_ADDR_WIDTH  = 28;
  localparam int DEF_BURST_LEN_WIDTH = 10;
  localparam int DEF_ADDR_STEP       = 8;

  // Native app port command encodings
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    WR_ISSUE = 3'd2,
    WR_DONE  = 3'd3,
    RD_CMD   = 3'd4,
    RD_DRAIN = 3'd5,
    RD_DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr_burst_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_burst_if / ddr_app_if
// Description : ddr_burst_if carries the burst request bus between the
//               DDR/cache initiator (master) and the burst responder (slave).
//               ddr_app_if carries the simplified DDR native app port between
//               the burst responder (master) and the DDR controller (slave).
// Ports       : burst bus - rd/wr req, len, addr, write data, data_req,
//                           read data/valid, finish pulses, busy
//               app port  - cmd channel (en/cmd/addr/rdy), write data channel
//                           (wren/end/data/rdy), read return (data/valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_burst_if #(
  parameter int DDR_DATA_WIDTH  = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int BURST_LEN_WIDTH = 10
);
  logic                       rd_burst_req;
  logic                       wr_burst_req;
  logic [BURST_LEN_WIDTH-1:0] rd_burst_len;
  logic [BURST_LEN_WIDTH-1:0] wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0]  rd_burst_addr;
  logic [DDR_ADDR_WIDTH-1:0]  wr_burst_addr;
  logic [DDR_DATA_WIDTH-1:0]  wr_burst_data;
  logic                       wr_burst_data_req;
  logic                       rd_burst_data_valid;
  logic [DDR_DATA_WIDTH-1:0]  rd_burst_data;
  logic                       rd_burst_finish;
  logic                       wr_burst_finish;
  logic                       busy;

  modport master (
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );

  modport slave (
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );
endinterface

interface ddr_app_if #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28
);
  logic                      app_en;
  logic [2:0]                app_cmd;
  logic [DDR_ADDR_WIDTH-1:0] app_addr;
  logic                      app_rdy;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic [DDR_DATA_WIDTH-1:0] app_wdf_data;
  logic                      app_wdf_rdy;
  logic [DDR_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/ddr_rd_return_reg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_return_reg
// Description : Registers read returns from the app port onto the burst bus
//               (one cycle latency) and counts the returned beats.
// Ports       : clk, rst          - clock, async active-high reset
//               active            - responder busy; returns ignored when low
//               clear             - zero the return counter (new burst)
//               app_rd_data/valid - raw read return from the controller
//               rd_burst_data/valid, ret_cnt - registered beat and count
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rd_return_reg #(
  parameter int DDR_DATA_WIDTH  = 128,
  parameter int BURST_LEN_WIDTH = 10
) (
  input  wire                        clk,
  input  wire                        rst,
  input  wire                        active,
  input  wire                        clear,
  input  wire [DDR_DATA_WIDTH-1:0]   app_rd_data,
  input  wire                        app_rd_data_valid,
  output logic [DDR_DATA_WIDTH-1:0]  rd_burst_data,
  output logic                       rd_burst_data_valid,
  output logic [BURST_LEN_WIDTH-1:0] ret_cnt
);

  logic w_take;

  // Returns arriving while idle are stray and must produce no output
  assign w_take = active && app_rd_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_burst_data       <= '0;
      rd_burst_data_valid <= 1'b0;
      ret_cnt             <= '0;
    end else begin
      rd_burst_data_valid <= w_take;
      if (w_take) begin
        rd_burst_data <= app_rd_data;
      end
      if (clear) begin
        ret_cnt <= '0;
      end else if (w_take) begin
        ret_cnt <= ret_cnt + BURST_LEN_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : ddr_burst_responder
// Description : Accepts read/write burst requests (start address, length)
//               and executes them beat by beat on a simplified DDR native
//               app port. Generates write-data requests, read data/valid and
//               one-cycle finish pulses for the initiator.
// Ports       : mem_clk             - clock
//               rst                 - async active-high reset
//               init_calib_complete - DDR ready; gates request acceptance
//               burst (slave)       - burst request bus from initiator
//               app (master)        - native app port to DDR controller
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_burst_responder
  import ddr_burst_responder_pkg::*;
#(
  parameter int DDR_DATA_WIDTH  = DEF_DDR_DATA_WIDTH,
  parameter int DDR_ADDR_WIDTH  = DEF_DDR_ADDR_WIDTH,
  parameter int BURST_LEN_WIDTH = DEF_BURST_LEN_WIDTH,
  parameter int ADDR_STEP       = DEF_ADDR_STEP
) (
  input  wire        mem_clk,
  input  wire        rst,
  input  wire        init_calib_complete,
  ddr_burst_if.slave burst,
  ddr_app_if.master  app
);

  state_t r_state;
  state_t w_state_nx;

  logic [DDR_ADDR_WIDTH-1:0]  r_cur_addr;
  logic [BURST_LEN_WIDTH-1:0] r_len;
  logic [BURST_LEN_WIDTH-1:0] r_wr_cnt;
  logic [BURST_LEN_WIDTH-1:0] r_cmd_cnt;
  logic [BURST_LEN_WIDTH-1:0] w_ret_cnt;
  logic                       r_cmd_done;
  logic                       r_data_done;
  logic                       r_issue_first;
  logic [DDR_DATA_WIDTH-1:0]  r_wdata;

  logic       w_accept_wr;
  logic       w_accept_rd;
  logic       w_cmd_acc;
  logic       w_data_acc;
  logic       w_beat_done;
  logic       w_rd_cmd_acc;
  logic       w_app_en;
  logic [2:0] w_app_cmd;
  logic       w_wren;
  logic       w_data_req;
  logic       w_wr_fin;
  logic       w_rd_fin;

  localparam logic [DDR_ADDR_WIDTH-1:0]  c_addr_step = DDR_ADDR_WIDTH'(ADDR_STEP);
  localparam logic [BURST_LEN_WIDTH-1:0] c_one       = BURST_LEN_WIDTH'(1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx   = r_state;
    w_accept_wr  = 1'b0;
    w_accept_rd  = 1'b0;
    w_cmd_acc    = 1'b0;
    w_data_acc   = 1'b0;
    w_beat_done  = 1'b0;
    w_rd_cmd_acc = 1'b0;
    w_app_en     = 1'b0;
    w_app_cmd    = CMD_WRITE;
    w_wren       = 1'b0;
    w_data_req   = 1'b0;
    w_wr_fin     = 1'b0;
    w_rd_fin     = 1'b0;

    case (r_state)
      IDLE: begin
        if (init_calib_complete) begin
          // Write wins when both requests are pending
          if (burst.wr_burst_req) begin
            w_accept_wr = 1'b1;
            w_state_nx  = (burst.wr_burst_len == '0) ? WR_DONE : WR_REQ;
          end else if (burst.rd_burst_req) begin
            w_accept_rd = 1'b1;
            w_state_nx  = (burst.rd_burst_len == '0) ? RD_DONE : RD_CMD;
          end
        end
      end

      WR_REQ: begin
        w_data_req = 1'b1;
        w_state_nx = WR_ISSUE;
      end

      WR_ISSUE: begin
        // Command and data channels complete independently; each strobe
        // is withdrawn as soon as its own channel has taken it.
        w_app_en   = !r_cmd_done;
        w_app_cmd  = CMD_WRITE;
        w_wren     = !r_data_done;
        w_cmd_acc  = w_app_en && app.app_rdy;
        w_data_acc = w_wren && app.app_wdf_rdy;
        if ((r_cmd_done || w_cmd_acc) && (r_data_done || w_data_acc)) begin
          w_beat_done = 1'b1;
          w_state_nx  = ((r_wr_cnt + c_one) == r_len) ? WR_DONE : WR_REQ;
        end
      end

      WR_DONE: begin
        w_wr_fin   = 1'b1;
        w_state_nx = IDLE;
      end

      RD_CMD: begin
        w_app_en  = 1'b1;
        w_app_cmd = CMD_READ;
        if (app.app_rdy) begin
          w_rd_cmd_acc = 1'b1;
          if ((r_cmd_cnt + c_one) == r_len) begin
            w_state_nx = RD_DRAIN;
          end
        end
      end

      RD_DRAIN: begin
        // ret_cnt and the registered valid update on the same edge, so the
        // cycle that sees ret_cnt==len is the last valid beat itself; the
        // finish pulse therefore lands one cycle later.
        if (w_ret_cnt == r_len) begin
          w_state_nx = RD_DONE;
        end
      end

      RD_DONE: begin
        w_rd_fin   = 1'b1;
        w_state_nx = IDLE;
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, length, beat counters, channel-done flags, write data
  // --------------------------------------------------------------------------
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_cur_addr    <= '0;
      r_len         <= '0;
      r_wr_cnt      <= '0;
      r_cmd_cnt     <= '0;
      r_cmd_done    <= 1'b0;
      r_data_done   <= 1'b0;
      r_issue_first <= 1'b0;
      r_wdata       <= '0;
    end else begin
      // WR_REQ always lasts exactly one cycle and leads to WR_ISSUE
      r_issue_first <= (r_state == WR_REQ);
      if (r_issue_first) begin
        r_wdata <= burst.wr_burst_data;
      end

      if (w_accept_wr) begin
        r_cur_addr  <= burst.wr_burst_addr;
        r_len       <= burst.wr_burst_len;
        r_wr_cnt    <= '0;
        r_cmd_cnt   <= '0;
        r_cmd_done  <= 1'b0;
        r_data_done <= 1'b0;
      end else if (w_accept_rd) begin
        r_cur_addr  <= burst.rd_burst_addr;
        r_len       <= burst.rd_burst_len;
        r_wr_cnt    <= '0;
        r_cmd_cnt   <= '0;
        r_cmd_done  <= 1'b0;
        r_data_done <= 1'b0;
      end else if (w_beat_done) begin
        r_wr_cnt    <= r_wr_cnt + c_one;
        r_cur_addr  <= r_cur_addr + c_addr_step;
        r_cmd_done  <= 1'b0;
        r_data_done <= 1'b0;
      end else if (w_rd_cmd_acc) begin
        r_cmd_cnt  <= r_cmd_cnt + c_one;
        r_cur_addr <= r_cur_addr + c_addr_step;
      end else begin
        if (w_cmd_acc) begin
          r_cmd_done <= 1'b1;
        end
        if (w_data_acc) begin
          r_data_done <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read return path
  // --------------------------------------------------------------------------
  ddr_rd_return_reg #(
    .DDR_DATA_WIDTH  (DDR_DATA_WIDTH),
    .BURST_LEN_WIDTH (BURST_LEN_WIDTH)
  ) u_rd_return (
    .clk                 (mem_clk),
    .rst                 (rst),
    .active              (r_state != IDLE),
    .clear               (w_accept_wr || w_accept_rd),
    .app_rd_data         (app.app_rd_data),
    .app_rd_data_valid   (app.app_rd_data_valid),
    .rd_burst_data       (burst.rd_burst_data),
    .rd_burst_data_valid (burst.rd_burst_data_valid),
    .ret_cnt             (w_ret_cnt)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign app.app_en       = w_app_en;
  assign app.app_cmd      = w_app_cmd;
  assign app.app_addr     = w_app_en ? r_cur_addr : '0;
  assign app.app_wdf_wren = w_wren;
  assign app.app_wdf_end  = w_wren;
  // The initiator's beat is only valid on the bus during the first issue
  // cycle; afterwards the captured copy is replayed under backpressure.
  assign app.app_wdf_data = !w_wren       ? '0 :
                            r_issue_first ? burst.wr_burst_data : r_wdata;

  assign burst.wr_burst_data_req = w_data_req;
  assign burst.wr_burst_finish   = w_wr_fin;
  assign burst.rd_burst_finish   = w_rd_fin;
  assign burst.busy              = (r_state != IDLE);

endmodule
`default_nettype wire
